// File: rtl/bkm_exp2_pkg.sv
// Shared fixed-point format and constants for the BKM log2/exp2 stages.
// Numbers are signed 65-bit with 32 fraction bits.
package fixedpoint;

  localparam int fractional_bits = 32;

  typedef logic signed [64:0] number;

  localparam number ONE     = 65'sh0_0000_0001_0000_0000;
  localparam number ZERO    = 65'sh0;
  localparam number MAX_POS = {1'b0, {64{1'b1}}};

  // log2(1 + 2^-i) scaled by 2^32; entry 0 is exactly 1.0
  localparam number LOG2_TABLE [32] = '{
    65'sd4294967296, 65'sd2512394810, 65'sd1382670639, 65'sd729822324,
    65'sd375650043,  65'sd190671291,  65'sd96069025,   65'sd48220695,
    65'sd24157255,   65'sd12090400,   65'sd6048149,    65'sd3024812,
    65'sd1512591,    65'sd756342,     65'sd378182,     65'sd189094,
    65'sd94548,      65'sd47274,      65'sd23637,      65'sd11819,
    65'sd5909,       65'sd2955,       65'sd1477,       65'sd739,
    65'sd369,        65'sd185,        65'sd92,         65'sd46,
    65'sd23,         65'sd12,         65'sd6,          65'sd3
  };

endpackage

// File: rtl/bkm_exp2_stage.sv
// One BKM exp2 iteration: conditionally multiply x by (1 + 2^-IDX) and
// retire log2(1 + 2^-IDX) from the remaining fraction.
module bkm_exp2_stage
  import fixedpoint::*;
#(
  parameter int IDX = 0
) (
  input  logic               clk,
  input  number              x_in,
  input  number              f_in,
  input  logic signed [32:0] n_in,
  output number              x_out,
  output number              f_out,
  output logic signed [32:0] n_out
);

  localparam number STEP = LOG2_TABLE[IDX];

  number t;

  assign t = x_in + (x_in >>> IDX);

  always_ff @(posedge clk) begin
    if (f_in >= STEP) begin
      x_out <= t;
      f_out <= f_in - STEP;
    end else begin
      x_out <= x_in;
      f_out <= f_in;
    end
    n_out <= n_in;
  end

endmodule

// File: rtl/bkm_exp2.sv
// Fully pipelined 2^x: split x into integer n and fraction f, build 2^f with
// WIDTH BKM iterations, then scale by 2^n with saturation/underflow.
module bkm_exp2
  import fixedpoint::*;
#(
  parameter int WIDTH = 28
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  number num1,
  output number exp2,
  output logic  out_valid
);

  // WIDTH must not exceed the 32 entries of LOG2_TABLE
  localparam int LATENCY = WIDTH + 2;

  function automatic number scale_out(input number x, input logic signed [32:0] n);
    logic signed [32:0] rsh;
    rsh = -n;
    if (n > 33'sd31)
      scale_out = MAX_POS;
    else if (n >= 33'sd0)
      scale_out = x <<< n[4:0];
    else if (n >= -33'sd32)
      scale_out = x >>> rsh[5:0];
    else
      scale_out = ZERO;
  endfunction

  number              x_p0;
  number              f_p0;
  logic signed [32:0] n_p0;

  number              x_s [WIDTH+1];
  number              f_s [WIDTH+1];
  logic signed [32:0] n_s [WIDTH+1];

  logic [LATENCY-1:0] vld_pipe;

  // stage 0: split input, start x at 1.0
  always_ff @(posedge clk) begin
    x_p0 <= ONE;
    f_p0 <= {33'd0, num1[31:0]};
    n_p0 <= num1[64:32];
  end

  assign x_s[0] = x_p0;
  assign f_s[0] = f_p0;
  assign n_s[0] = n_p0;

  // stages 1..WIDTH: BKM iterations
  for (genvar i = 0; i < WIDTH; i++) begin : g_iter
    bkm_exp2_stage #(
      .IDX(i)
    ) u_stage (
      .clk  (clk),
      .x_in (x_s[i]),
      .f_in (f_s[i]),
      .n_in (n_s[i]),
      .x_out(x_s[i+1]),
      .f_out(f_s[i+1]),
      .n_out(n_s[i+1])
    );
  end

  // output stage: scale by 2^n; exp2 is forced to zero on idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      exp2     <= ZERO;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], in_valid};
      exp2     <= vld_pipe[WIDTH] ? scale_out(x_s[WIDTH], n_s[WIDTH]) : ZERO;
    end
  end

  assign out_valid = vld_pipe[LATENCY-1];

endmodule

// File: tb/tb_bkm_exp2.sv
// Scoreboard bench for bkm_exp2: expectations are computed from a real-valued
// 2^x model when a sample is driven and compared when out_valid rises.
module tb_bkm_exp2;
  import fixedpoint::*;

  localparam int WIDTH   = 28;
  localparam int LATENCY = WIDTH + 2;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  logic  in_valid = 1'b0;
  number num1 = '0;
  number exp2;
  logic  out_valid;

  bkm_exp2 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .num1     (num1),
    .exp2     (exp2),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  typedef struct {
    number val;
    real   lo;
    real   hi;
    bit    exact;
    int    due;
  } exp_t;

  exp_t sb[$];

  function automatic number fx(input int ip);
    number r;
    r = number'(ip) <<< 32;
    return r;
  endfunction

  function automatic real to_real(input number v);
    real r;
    r = 0.0;
    for (int k = 3; k >= 0; k--) r = r * 65536.0 + real'(int'(v[k*16 +: 16]));
    return r;
  endfunction

  function automatic exp_t model(input number v, input int due);
    exp_t e;
    logic signed [32:0] ip;
    number one;
    real xr, rv, tol;
    one = 65'sd1;
    ip = v[64:32];
    e.due = due; e.exact = 1'b1; e.lo = 0.0; e.hi = 0.0; e.val = '0;
    if (ip > 33'sd31) begin
      e.val = {1'b0, {64{1'b1}}};
    end else if (ip < -33'sd32) begin
      e.val = '0;
    end else if (v[31:0] == 32'd0) begin
      e.val = one <<< int'(ip + 33'sd32);
    end else begin
      e.exact = 1'b0;
      xr  = real'(int'(ip)) + (real'(int'(v[31:16])) * 65536.0 + real'(int'(v[15:0]))) / 4294967296.0;
      rv  = 2.0 ** (xr + 32.0);
      tol = rv / 67108864.0 + ((ip < 0) ? 1.5 : 0.0);
      e.lo = rv - tol;
      e.hi = rv + tol;
    end
    return e;
  endfunction

  // call right after a falling edge; the sample is taken at the next rising edge
  task automatic drive(input bit v, input number val);
    in_valid = v;
    num1     = val;
    if (v) sb.push_back(model(val, cyc + LATENCY));
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || exp2 !== '0) begin
        errors++;
        $display("FAIL reset_hold: out_valid=%b exp2=%h, required 0 and 0", out_valid, exp2);
      end
      in_valid = 1'b1;
      num1     = fx(c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, '0);
    for (int c = 0; c < LATENCY + 2; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || exp2 !== '0) begin
        errors++;
        $display("FAIL reset_leak: cycle %0d out_valid=%b exp2=%h, required 0 and 0", c, out_valid, exp2);
      end
    end
  endtask

  task automatic test_zero();
    exp_t e;
    real got;
    int seen = 0;
    @(negedge clk);
    drive(1'b1, '0);
    for (int c = 0; c < LATENCY + 4; c++) begin
      @(negedge clk);
      drive(1'b0, '0);
      checks++;
      if (out_valid) begin
        seen++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL zero_extra: out_valid=1 exp2=%h at cycle %0d, required out_valid=0", exp2, cyc);
        end else begin
          e = sb.pop_front();
          got = to_real(exp2);
          if (cyc != e.due || exp2 !== e.val) begin
            errors++;
            $display("FAIL zero: exp2=%h at cycle %0d, required %h at cycle %0d", exp2, cyc, e.val, e.due);
          end
        end
      end else if (exp2 !== '0) begin
        errors++;
        $display("FAIL zero_idle: exp2=%h with out_valid=0, required 0", exp2);
      end
    end
    checks++;
    if (seen != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL zero_pulse: out_valid high %0d cycles, required 1", seen);
      sb.delete();
    end
  endtask

  task automatic run_list(input string name, input number stim[$]);
    exp_t e;
    real got;
    int k = 0;
    for (int c = 0; c < stim.size() + LATENCY + 8; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s_extra: out_valid=1 exp2=%h at cycle %0d, required out_valid=0", name, exp2, cyc);
        end else begin
          e = sb.pop_front();
          got = to_real(exp2);
          if (cyc != e.due || (e.exact ? (exp2 !== e.val) : (got < e.lo || got > e.hi))) begin
            errors++;
            $display("FAIL %s: exp2=%h (%0.1f) at cycle %0d, required %h / [%0.1f, %0.1f] at cycle %0d",
                     name, exp2, got, cyc, e.val, e.lo, e.hi, e.due);
          end
        end
      end else if (exp2 !== '0) begin
        errors++;
        $display("FAIL %s_idle: exp2=%h with out_valid=0, required 0", name, exp2);
      end
      if (k < stim.size()) drive(1'b1, stim[k]);
      else drive(1'b0, '0);
      k++;
      if (k > stim.size() && sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d outputs missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_pairs();
    number stim[$];
    stim = '{fx(1), fx(-1)};
    run_list("one_minus_one", stim);
    stim = '{65'sh0_0000_0000_8000_0000};
    run_list("sqrt2", stim);
  endtask

  task automatic test_saturation();
    number stim[$];
    stim = '{fx(32), fx(-40), fx(31), fx(-32), fx(-33), fx(100), fx(31) | 65'sh0_FFFF_FFFF};
    run_list("saturation", stim);
  endtask

  task automatic test_back_to_back();
    number stim[$];
    logic signed [32:0] ip;
    logic [31:0] fr;
    for (int i = 0; i < 100; i++) begin
      ip = 33'(int'($urandom_range(0, 63)) - 32);
      fr = $urandom;
      stim.push_back({ip, fr});
    end
    run_list("back_to_back", stim);
  endtask

  task automatic test_reset_flight();
    exp_t e;
    real got;
    int seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flight_early: out_valid=%b at cycle %0d, required 0", out_valid, cyc);
      end
      drive(1'b1, fx(c % 5) | 65'sh0_1234_5678);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || exp2 !== '0) begin
      errors++;
      $display("FAIL flight_in_reset: out_valid=%b exp2=%h, required 0 and 0", out_valid, exp2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, fx(1));
    for (int c = 0; c < LATENCY + 4; c++) begin
      @(negedge clk);
      drive(1'b0, '0);
      checks++;
      if (out_valid) begin
        seen++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL flight_ghost: out_valid=1 exp2=%h at cycle %0d, required out_valid=0", exp2, cyc);
        end else begin
          e = sb.pop_front();
          got = to_real(exp2);
          if (cyc != e.due || exp2 !== e.val) begin
            errors++;
            $display("FAIL flight_after: exp2=%h at cycle %0d, required %h at cycle %0d", exp2, cyc, e.val, e.due);
          end
        end
      end else if (exp2 !== '0) begin
        errors++;
        $display("FAIL flight_idle: exp2=%h with out_valid=0, required 0", exp2);
      end
    end
    checks++;
    if (seen != 1 || sb.size() != 0) begin
      errors++;
      $display("FAIL flight_count: %0d outputs after release, required 1", seen);
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_pairs();
    test_saturation();
    test_back_to_back();
    test_reset_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
